// File: rtl/mul_stream_loader.sv
// Stream loader for the 131x128 multiplier: packs A/B from 32-bit words, starts the
// accelerator, captures the product and drains it as nine words. Optional: MUL_STREAM_OVERSIZE_CHK_EN.
module mul_stream_loader #(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              acc_start,
  output logic [130:0]      acc_a,
  output logic [127:0]      acc_b,
  input  logic              acc_ready,
  input  logic [258:0]      acc_p,
  output logic              busy,
  output logic              err_timeout
`ifdef MUL_STREAM_OVERSIZE_CHK_EN
  ,
  output logic              err_oversize
`endif
);

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYC - 1);

  state_t         state_r;
  logic [2:0]     cnt_r;
  logic [15:0]    tcnt_r;
  logic [3:0]     idx_r;
  logic [287:0]   prod_r;
  logic [130:0]   acc_a_r;
  logic [127:0]   acc_b_r;
  logic           s_ready_r;
  logic           m_valid_r;
  logic [31:0]    m_data_r;
  logic           m_last_r;
  logic           acc_start_r;
  logic           busy_r;
  logic           err_timeout_r;
`ifdef MUL_STREAM_OVERSIZE_CHK_EN
  logic           err_oversize_r;
`endif

  logic           s_hs_s;
  logic           m_hs_s;
  logic [3:0]     idx_nxt_s;

  // Picks one 32-bit word of the zero-extended product; out-of-range indices read as zero.
  function automatic logic [31:0] word_sel(input logic [287:0] v, input logic [3:0] i);
    if (i > 4'd8) begin
      return 32'd0;
    end else begin
      return v[32*int'(i) +: 32];
    end
  endfunction

`ifdef MUL_STREAM_OVERSIZE_CHK_EN
  // A word 4 only contributes bits 2:0 to the 131-bit operand.
  function automatic logic oversize(input logic [31:0] w);
    return |w[31:3];
  endfunction
`endif

  // Handshake qualifiers
  always_comb begin
    s_hs_s    = s_valid && s_ready_r;
    m_hs_s    = m_valid_r && m_ready;
    idx_nxt_s = idx_r + 4'd1;
  end

  // Control FSM; every output register is loaded with its value for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_LOAD_A;
      cnt_r          <= 3'd0;
      tcnt_r         <= 16'd0;
      idx_r          <= 4'd0;
      prod_r         <= 288'd0;
      acc_a_r        <= 131'd0;
      acc_b_r        <= 128'd0;
      s_ready_r      <= 1'b0;
      m_valid_r      <= 1'b0;
      m_data_r       <= 32'd0;
      m_last_r       <= 1'b0;
      acc_start_r    <= 1'b0;
      busy_r         <= 1'b0;
      err_timeout_r  <= 1'b0;
`ifdef MUL_STREAM_OVERSIZE_CHK_EN
      err_oversize_r <= 1'b0;
`endif
    end else begin
      acc_start_r    <= 1'b0;
      err_timeout_r  <= 1'b0;
`ifdef MUL_STREAM_OVERSIZE_CHK_EN
      err_oversize_r <= 1'b0;
`endif
      case (state_r)
        ST_LOAD_A: begin
          s_ready_r <= 1'b1;
          if (s_hs_s) begin
            busy_r <= 1'b1;
            case (cnt_r)
              3'd0:    acc_a_r[31:0]    <= s_data;
              3'd1:    acc_a_r[63:32]   <= s_data;
              3'd2:    acc_a_r[95:64]   <= s_data;
              3'd3:    acc_a_r[127:96]  <= s_data;
              3'd4:    acc_a_r[130:128] <= s_data[2:0];
              default: acc_a_r          <= acc_a_r;
            endcase
            if (cnt_r == 3'd4) begin
              cnt_r <= 3'd0;
`ifdef MUL_STREAM_OVERSIZE_CHK_EN
              if (oversize(s_data)) begin
                err_oversize_r <= 1'b1;
                busy_r         <= 1'b0;
              end else begin
                state_r <= ST_LOAD_B;
              end
`else
              state_r <= ST_LOAD_B;
`endif
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        ST_LOAD_B: begin
          if (s_hs_s) begin
            case (cnt_r)
              3'd0:    acc_b_r[31:0]   <= s_data;
              3'd1:    acc_b_r[63:32]  <= s_data;
              3'd2:    acc_b_r[95:64]  <= s_data;
              3'd3:    acc_b_r[127:96] <= s_data;
              default: acc_b_r         <= acc_b_r;
            endcase
            if (cnt_r == 3'd3) begin
              cnt_r       <= 3'd0;
              state_r     <= ST_START;
              s_ready_r   <= 1'b0;
              acc_start_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        ST_START: begin
          tcnt_r  <= 16'd0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // A late acc_ready still beats a timeout that lands on the same cycle.
          if (acc_ready) begin
            prod_r    <= {29'd0, acc_p};
            m_valid_r <= 1'b1;
            m_data_r  <= acc_p[31:0];
            m_last_r  <= 1'b0;
            idx_r     <= 4'd0;
            tcnt_r    <= 16'd0;
            state_r   <= ST_DRAIN;
          end else if (tcnt_r == TMAX) begin
            err_timeout_r <= 1'b1;
            s_ready_r     <= 1'b1;
            busy_r        <= 1'b0;
            tcnt_r        <= 16'd0;
            state_r       <= ST_LOAD_A;
          end else begin
            tcnt_r <= tcnt_r + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (m_hs_s) begin
            if (idx_r == 4'd8) begin
              m_valid_r <= 1'b0;
              m_data_r  <= 32'd0;
              m_last_r  <= 1'b0;
              idx_r     <= 4'd0;
              s_ready_r <= 1'b1;
              busy_r    <= 1'b0;
              state_r   <= ST_LOAD_A;
            end else begin
              idx_r    <= idx_nxt_s;
              m_data_r <= word_sel(prod_r, idx_nxt_s);
              m_last_r <= (idx_nxt_s == 4'd8);
            end
          end
        end
        default: begin
          state_r   <= ST_LOAD_A;
          cnt_r     <= 3'd0;
          idx_r     <= 4'd0;
          s_ready_r <= 1'b0;
          m_valid_r <= 1'b0;
          m_last_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready      = s_ready_r;
  assign m_valid      = m_valid_r;
  assign m_data       = m_data_r;
  assign m_last       = m_last_r;
  assign acc_start    = acc_start_r;
  assign acc_a        = acc_a_r;
  assign acc_b        = acc_b_r;
  assign busy         = busy_r;
  assign err_timeout  = err_timeout_r;
`ifdef MUL_STREAM_OVERSIZE_CHK_EN
  assign err_oversize = err_oversize_r;
`endif

endmodule
